// File: rtl/fft16_input_loader.sv
// Serial-to-parallel loader for the 16-point FFT: collects 16 complex samples per frame
// into ping-pong banks and presents a completed frame as 16 parallel lanes.
module fft16_input_loader #(
    parameter int DATA_W = 16,
    parameter int N      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_real,
    input  logic [DATA_W-1:0]   in_im,
    input  logic                in_last,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [N*DATA_W-1:0] X_Real,
    output logic [N*DATA_W-1:0] X_Im,
    output logic                err_frame,
    output logic [7:0]          frame_count
);

    localparam int IDX_W  = $clog2(N);
    localparam int LANE_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    logic [LANE_W-1:0] mem [2][N];
    bank_state_t       bank_state [2];
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_bank;
    logic              rd_bank;

    logic              accept;
    logic              handoff;
    logic              last_lane;
    logic [LANE_W-1:0] sample;

    bank_state_t       state_nxt [2];
    logic              wr_bank_nxt;
    logic              rd_bank_nxt;
    logic [IDX_W-1:0]  wr_idx_nxt;
    logic              len_err;
    logic              present_nxt;
    logic [LANE_W-1:0] pres_lane [N];

    assign accept    = in_valid && in_ready;
    assign handoff   = frame_valid && frame_ready;
    assign last_lane = (wr_idx == IDX_W'(N - 1));
    assign sample    = {in_real, in_im};

    // Handoff only touches a FULL bank and accept only a non-FULL one, so they never collide.
    always_comb begin
        wr_bank_nxt = wr_bank;
        rd_bank_nxt = rd_bank;
        wr_idx_nxt  = wr_idx;
        len_err     = 1'b0;
        for (int b = 0; b < 2; b++) begin
            state_nxt[b] = bank_state[b];
            if (handoff && rd_bank == 1'(b)) begin
                state_nxt[b] = BANK_EMPTY;
            end
            if (accept && wr_bank == 1'(b)) begin
                if (last_lane) begin
                    state_nxt[b] = BANK_FULL;
                end else if (in_last) begin
                    state_nxt[b] = BANK_EMPTY;
                end else begin
                    state_nxt[b] = BANK_FILLING;
                end
            end
        end
        if (handoff) begin
            rd_bank_nxt = ~rd_bank;
        end
        if (accept) begin
            len_err = (last_lane != in_last);
            if (last_lane) begin
                wr_bank_nxt = ~wr_bank;
                wr_idx_nxt  = '0;
            end else if (in_last) begin
                wr_idx_nxt  = '0;
            end else begin
                wr_idx_nxt  = wr_idx + IDX_W'(1);
            end
        end
    end

    // View of the bank presented after this edge, including a sample landing on this edge.
    always_comb begin
        present_nxt = (state_nxt[rd_bank_nxt] == BANK_FULL);
        for (int i = 0; i < N; i++) begin
            pres_lane[i] = mem[rd_bank_nxt][i];
            if (accept && wr_bank == rd_bank_nxt && wr_idx == IDX_W'(i)) begin
                pres_lane[i] = sample;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the sample storage is cleared on reset because reset must leave all storage at 0.
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= BANK_EMPTY;
                for (int i = 0; i < N; i++) begin
                    mem[b][i] <= '0;
                end
            end
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
            X_Real      <= '0;
            X_Im        <= '0;
            err_frame   <= 1'b0;
            frame_count <= '0;
        end else begin
            if (accept) begin
                mem[wr_bank][wr_idx] <= sample;
            end
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= state_nxt[b];
            end
            wr_idx      <= wr_idx_nxt;
            wr_bank     <= wr_bank_nxt;
            rd_bank     <= rd_bank_nxt;
            in_ready    <= (state_nxt[wr_bank_nxt] != BANK_FULL);
            frame_valid <= present_nxt;
            // A FULL bank is never written, so reloading it each cycle keeps the lanes stable.
            if (present_nxt) begin
                for (int i = 0; i < N; i++) begin
                    X_Real[DATA_W*i +: DATA_W] <= pres_lane[i][LANE_W-1:DATA_W];
                    X_Im[DATA_W*i +: DATA_W]   <= pres_lane[i][DATA_W-1:0];
                end
            end
            if (len_err) begin
                err_frame <= 1'b1;
            end
            if (handoff) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft16_input_loader.sv
// Directed bench for fft16_input_loader with a frame scoreboard fed by the accepted samples.
module tb_fft16_input_loader;

    localparam int DW = 16;
    localparam int NL = 16;

    typedef struct packed {
        logic [NL*DW-1:0] re;
        logic [NL*DW-1:0] im;
    } frame_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_real = '0;
    logic [DW-1:0]   in_im = '0;
    logic            in_last = 1'b0;
    logic            frame_valid;
    logic            frame_ready = 1'b0;
    logic [NL*DW-1:0] X_Real;
    logic [NL*DW-1:0] X_Im;
    logic            err_frame;
    logic [7:0]      frame_count;

    fft16_input_loader #(.DATA_W(DW), .N(NL)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_im       (in_im),
        .in_last     (in_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .X_Real      (X_Real),
        .X_Im        (X_Im),
        .err_frame   (err_frame),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int       checks   = 0;
    int       failures = 0;
    frame_t   exp_q[$];
    frame_t   cur;
    int       cur_idx;
    logic     err_exp;
    logic [7:0] exp_count;
    logic     obs_ready;
    logic     obs_fv;

    task automatic check(input string tag, input logic [NL*DW-1:0] obs, input logic [NL*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample registered outputs, score any handoff, update the model.
    task automatic step(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic last, input logic fr);
        frame_t f;
        in_valid    = v;
        in_real     = re;
        in_im       = im;
        in_last     = last;
        frame_ready = fr;
        obs_ready   = in_ready;
        obs_fv      = frame_valid;
        if (frame_valid && fr) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL handoff_unexpected observed=frame expected=none");
            end else begin
                f = exp_q.pop_front();
                check("frame_re", X_Real, f.re);
                check("frame_im", X_Im, f.im);
                exp_count++;
            end
        end
        if (v && in_ready) begin
            cur.re[DW*cur_idx +: DW] = re;
            cur.im[DW*cur_idx +: DW] = im;
            if (cur_idx == NL - 1) begin
                exp_q.push_back(cur);
                if (!last) err_exp = 1'b1;
                cur_idx = 0;
            end else if (last) begin
                err_exp = 1'b1;
                cur_idx = 0;
            end else begin
                cur_idx++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        frame_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        cur = '0;
        cur_idx = 0;
        err_exp = 1'b0;
        exp_count = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int k;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state, then one well-formed frame with the consumer ready.
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_x_real", X_Real, '0);
        check("rst_x_im", X_Im, '0);
        check("rst_err", err_frame, 1'b0);
        check("rst_count", frame_count, 8'd0);
        for (int i = 0; i < NL; i++) step(1'b1, DW'(i), DW'(0 - i), i == NL - 1, 1'b1);
        check("t1_valid_after_last", frame_valid, 1'b1);
        check("t1_lane3_re", X_Real[3*DW +: DW], 16'h0003);
        check("t1_lane3_im", X_Im[3*DW +: DW], 16'hFFFD);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("t1_valid_one_cycle", frame_valid, 1'b0);
        check("t1_count", frame_count, 8'd1);
        check("t1_count_model", frame_count, exp_count);
        check("t1_err", err_frame, 1'b0);

        // Consumer stalled: two frames load, the third stalls, nothing is dropped.
        do_reset();
        k = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, DW'(k), DW'(16'h1000 + k), (k % NL) == NL - 1, 1'b0);
            check("t2_ready", obs_ready, c < 32);
            if (obs_ready) k++;
            if (c >= 15) check("t2_hold", X_Real, exp_q[0].re);
        end
        check("t2_stalled_at", k, 32);
        step(1'b1, DW'(k), DW'(16'h1000 + k), 1'b0, 1'b1);
        check("t2_release_no_accept", obs_ready, 1'b0);
        check("t2_frame2_valid", frame_valid, 1'b1);
        check("t2_frame2_lane0", X_Real[DW-1:0], 16'd16);
        check("t2_ready_rises", in_ready, 1'b1);
        check("t2_count", frame_count, exp_count);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("t2_drained", exp_q.size(), 0);

        // Continuous stream with consumer always ready: no bubbles.
        do_reset();
        for (int c = 0; c < 64; c++) begin
            step(1'b1, DW'(c), ~DW'(c), (c % NL) == NL - 1, 1'b1);
            check("t3_ready", obs_ready, 1'b1);
        end
        idle(4);
        check("t3_count", frame_count, 8'd4);
        check("t3_count_model", frame_count, exp_count);
        check("t3_drained", exp_q.size(), 0);

        // Short frame is discarded and flagged; the following good frame is delivered.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0500 + i), DW'(16'h0A00 + i), i == 4, 1'b1);
        check("t4_err_set", err_frame, 1'b1);
        check("t4_no_frame", frame_valid, 1'b0);
        for (int i = 0; i < NL; i++) step(1'b1, DW'(16'h2000 + i), DW'(16'hC000 + i), i == NL - 1, 1'b1);
        idle(3);
        check("t4_count", frame_count, 8'd1);
        check("t4_err_sticky", err_frame, 1'b1);
        check("t4_drained", exp_q.size(), 0);

        // Missing in_last: frame still completes, error flagged.
        do_reset();
        for (int i = 0; i < NL; i++) step(1'b1, DW'(16'h7000 + 3*i), DW'(16'h8000 + i), 1'b0, 1'b1);
        idle(3);
        check("t5_count", frame_count, 8'd1);
        check("t5_err", err_frame, err_exp);
        check("t5_err_abs", err_frame, 1'b1);
        check("t5_drained", exp_q.size(), 0);

        // Reset mid-frame with a full frame pending.
        do_reset();
        for (int i = 0; i < NL + 9; i++) step(1'b1, DW'(16'h3000 + i), DW'(16'h4000 + i), (i % NL) == NL - 1, 1'b0);
        check("t6_pending", frame_valid, 1'b1);
        do_reset();
        check("t6_rst_valid", frame_valid, 1'b0);
        check("t6_rst_ready", in_ready, 1'b1);
        check("t6_rst_x_real", X_Real, '0);
        check("t6_rst_x_im", X_Im, '0);
        check("t6_rst_count", frame_count, 8'd0);
        for (int i = 0; i < NL; i++) step(1'b1, DW'(16'h5550 + i), DW'(16'hAAA0 - i), i == NL - 1, 1'b1);
        idle(3);
        check("t6_count", frame_count, 8'd1);
        check("t6_err", err_frame, 1'b0);
        check("t6_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft16_input_loader.md
Name: fft16_input_loader

Overview:
- Serial-to-parallel front end for the 16-point FFT datapath.
- Accepts one complex sample per cycle over a valid/ready stream and collects 16 samples into a frame.
- Presents the frame as 16 parallel complex lanes to the first butterfly stage, whose lane i pairs with lane i+8.
- Ping-pong (two-bank) storage lets the next frame load while the current frame is held for the consumer.

Parameters:
- DATA_W, 16, width of each real and imaginary component (two's complement).
- N, 16, samples per frame; fixed at 16 for this datapath.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  loader can accept a sample.
- in_real  input  DATA_W  sample real part.
- in_im  input  DATA_W  sample imaginary part.
- in_last  input  1  marks the final sample of a frame.
- frame_valid  output  1  complete frame presented on X_Real/X_Im.
- frame_ready  input  1  consumer takes the frame.
- X_Real  output  N*DATA_W  lane i real part at bits [DATA_W*i+DATA_W-1 : DATA_W*i].
- X_Im  output  N*DATA_W  lane i imaginary part, same packing as X_Real.
- err_frame  output  1  sticky flag: frame length did not match N.
- frame_count  output  8  count of frames handed off; wraps 255->0.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-high on clk/rst.
  - Reset applies regardless of state, including mid-frame or with a frame pending.
  - Reset values: in_ready=1, frame_valid=0, X_Real=0, X_Im=0, err_frame=0, frame_count=0.
  - Reset clears wr_idx=0, wr_bank=0, rd_bank=0, both banks EMPTY, all storage 0.
  - A partial frame in progress at reset is discarded.
- Bank states: each bank is EMPTY, FILLING or FULL.
  - EMPTY->FILLING on the first accepted sample.
  - FILLING->FULL on acceptance at wr_idx=15.
  - FULL->EMPTY on the output handshake.
- Accept = in_valid && in_ready.
  - On accept, store {in_real, in_im} in bank wr_bank at lane wr_idx, then increment wr_idx.
  - At wr_idx=15: mark the bank FULL, toggle wr_bank, set wr_idx=0.
- in_ready = (bank wr_bank is not FULL).
  - Derived from registered state only; there is no combinational path from frame_ready.
- frame_valid = (bank rd_bank is FULL).
  - X_Real/X_Im are driven from bank rd_bank and stay stable while frame_valid=1.
  - When frame_valid=0, X_* hold their last values (0 after reset).
- Handoff = frame_valid && frame_ready.
  - Next edge: rd_bank becomes EMPTY, rd_bank toggles, frame_count increments.
- Latency:
  - Sample 15 accepted at edge t -> frame_valid=1 after edge t.
  - Handoff at edge t -> freed bank reports in_ready=1 after edge t.
- Throughput: continuous 1 sample/cycle is sustained when frame_ready is held high (no bubbles).
- Both banks FULL: in_ready=0 and input stalls; no sample is dropped or overwritten.
- Same-cycle accept of the last sample and handoff: the two operate on different banks, and both take effect.
- Frame length checks:
  - in_last on an accept with wr_idx<15 (short frame): err_frame<=1, wr_idx<=0, the bank returns to EMPTY, and the partial frame is discarded. frame_valid is unaffected.
  - Accept at wr_idx=15 with in_last=0 (long/missing marker): the frame still completes normally and err_frame<=1.
  - err_frame clears only on rst.
- Data is passed through unmodified: no scaling, no reordering. Lane i is the i-th accepted sample of the frame.

Test Plan:
- Reset, then stream samples real=i, im=-i for i=0..15 with in_last on i=15 and frame_ready=1 -> frame_valid=1 for exactly one cycle after the 16th accept. Lane 3 reads real=0x0003, im=0xFFFD. frame_count=1, err_frame=0.
- Hold frame_ready=0 and stream 40 samples back-to-back -> frames 1 and 2 load. in_ready=0 from sample 33 onward. Lane 0 of frame 1 is held stable. Releasing frame_ready for one cycle yields frame 2 (lane 0 = 16); in_ready rises the next cycle.
- Continuous stream of 64 samples with frame_ready=1 -> in_ready never drops. Four frames are delivered, and frame_count reaches 4.
- in_last asserted on the 5th sample, then 16 good samples -> err_frame=1 sticky. Exactly one frame is delivered, containing the 16 good samples. The short frame never appears.
- 16 samples with no in_last -> frame delivered and err_frame=1.
- rst asserted after 9 samples of a frame with a full frame pending -> next cycle frame_valid=0, in_ready=1, X_*=0, frame_count=0. A new 16-sample frame then completes correctly.
